layer3_stream_ctrl: RTL and testbench

- Streaming controller for the layer-3 local buffer, a 208-word × 128-bit dual-port SRAM behind the layer-3 SRAM wrapper.
- Accepts one 128-bit pixel vector per handshake from the layer-2 output stage and writes it through SRAM port A at sequential addresses.
- Reads words back through port B, trailing the write pointer, and presents them to the layer-3 compute stage over a valid/ready stream with a 2-entry output buffer.
- Owns every wrapper control pin, so the wrapper's equal-address redirect logic is never exercised.

---
 rtl/layer3_pkg.sv | 20 ++
 rtl/layer3_out_skid.sv | 45 ++++
 rtl/layer3_stream_ctrl.sv | 113 +++++++++++
 tb/tb_layer3_stream_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer3_pkg.sv
// rtl/layer3_pkg.sv - shared constants and types for the layer-3 stream controller
package layer3_pkg;

    localparam int DEPTH = 208;
    localparam int AW    = 8;
    localparam int DW    = 128;

    // Counter-width forms of the frame bounds, so compares stay at AW bits
    localparam logic [AW-1:0] DEPTH_CNT = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } state_t;

    typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/layer3_out_skid.sv
// rtl/layer3_out_skid.sv - 2-entry register FIFO holding words read back from port B
module layer3_out_skid
    import layer3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  word_t      push_data,
    input  logic       pop,
    output logic [1:0] count,
    output word_t      head
);

    word_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;

    // Head is read straight from storage, so it cannot change until it is popped
    assign head = mem[rd_ptr];

    // Storage, pointers and occupancy; the issue logic never pushes into a full buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/layer3_stream_ctrl.sv
// rtl/layer3_stream_ctrl.sv - writes a frame into the layer-3 SRAM and streams it back out
module layer3_stream_ctrl
    import layer3_pkg::*;
(
    input  logic          CK,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          frame_done,
    output logic          busy,
    output logic [AW-1:0] sram_a,
    output logic          sram_wean,
    output logic          sram_oea,
    output logic [DW-1:0] sram_dia,
    output logic [AW-1:0] sram_b,
    output logic          sram_webn,
    output logic          sram_oeb,
    output logic [DW-1:0] sram_dib,
    input  logic [DW-1:0] sram_dob
);

    state_t        state;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_issue;
    logic [AW-1:0] rd_cnt;
    logic          inflight;
    logic          wr_fire;
    logic          rd_fire;
    logic          pop;
    logic [1:0]    occ;
    word_t         head;

    // Write side: port A follows the write counter, data only driven on a real write
    assign in_ready  = (state == ACTIVE) && (wr_cnt < DEPTH_CNT);
    assign wr_fire   = in_valid && in_ready;
    assign sram_wean = ~wr_fire;
    assign sram_a    = wr_cnt;
    assign sram_dia  = wr_fire ? in_data : '0;
    assign sram_oea  = 1'b0;

    // Output side
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = head;
    assign out_last  = out_valid && (rd_cnt == LAST_IDX);
    assign busy      = (state != IDLE);

    // Read issue: only words already written, and only when the buffer slot is
    // guaranteed (a pop this cycle frees one, which sustains one word per cycle)
    assign rd_fire = (state != IDLE) && (rd_issue < wr_cnt) &&
                     (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign sram_oeb  = rd_fire;
    assign sram_webn = 1'b1;
    assign sram_dib  = '0;

    // When port B is idle during a write, park it one past the write address so
    // the two ports never present the same address while port A writes
    assign sram_b = (wr_fire && !rd_fire) ? (wr_cnt + AW'(1)) : rd_issue;

    layer3_out_skid u_skid (
        .clk       (CK),
        .rst       (rst),
        .push      (inflight),
        .push_data (sram_dob),
        .pop       (pop),
        .count     (occ),
        .head      (head)
    );

    // Frame sequencing, pointer advance and completion pulse
    always_ff @(posedge CK or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            rd_issue   <= '0;
            rd_cnt     <= '0;
            inflight   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            inflight   <= rd_fire;
            if (wr_fire) wr_cnt   <= wr_cnt + AW'(1);
            if (rd_fire) rd_issue <= rd_issue + AW'(1);
            if (pop)     rd_cnt   <= rd_cnt + AW'(1);
            case (state)
                IDLE: begin
                    if (start) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (wr_fire && (wr_cnt == LAST_IDX)) state <= FLUSH;
                end
                FLUSH: begin
                    if (pop && out_last) begin
                        state      <= IDLE;
                        wr_cnt     <= '0;
                        rd_issue   <= '0;
                        rd_cnt     <= '0;
                        inflight   <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer3_stream_ctrl.sv
// tb/tb_layer3_stream_ctrl.sv - directed self-checking bench for layer3_stream_ctrl
module tb_layer3_stream_ctrl;

    logic         CK = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_last;
    logic         frame_done;
    logic         busy;
    logic [7:0]   sram_a;
    logic         sram_wean;
    logic         sram_oea;
    logic [127:0] sram_dia;
    logic [7:0]   sram_b;
    logic         sram_webn;
    logic         sram_oeb;
    logic [127:0] sram_dib;
    logic [127:0] sram_dob = '0;

    int checks = 0;
    int errors = 0;

    layer3_stream_ctrl dut (
        .CK         (CK),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .busy       (busy),
        .sram_a     (sram_a),
        .sram_wean  (sram_wean),
        .sram_oea   (sram_oea),
        .sram_dia   (sram_dia),
        .sram_b     (sram_b),
        .sram_webn  (sram_webn),
        .sram_oeb   (sram_oeb),
        .sram_dib   (sram_dib),
        .sram_dob   (sram_dob)
    );

    always #5 CK = ~CK;

    // Dual-port SRAM: write on port A, registered read on port B
    logic [127:0] mem [208];
    always @(posedge CK) begin
        if (!sram_wean) mem[sram_a] <= sram_dia;
        if (sram_oeb)   sram_dob    <= mem[sram_b];
    end

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] gen(input logic [31:0] seed, input int idx);
        if (seed == 32'd0) return 128'(idx);
        return {seed, 32'(idx) ^ 32'h5a5a_0000, ~seed, 32'(idx)};
    endfunction

    // Monitor state, cleared at the start of each frame
    logic [31:0]  cur_seed = '0;
    int           wr_seen, oeb_seen, rx_cnt, data_err, last_err, addr_err;
    int           wseq_err, wdata_err, stall_err, fd_cnt, fd_cyc, last_hs_cyc;
    int           first_ov_cyc, first_acc_cyc;
    bit           seen_ov, seen_acc, prev_stall;
    logic [127:0] prev_data;

    always @(negedge CK) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (!sram_wean) begin
                if (sram_a == sram_b) addr_err++;
                if (sram_a !== 8'(wr_seen)) wseq_err++;
                if (sram_dia !== gen(cur_seed, wr_seen)) wdata_err++;
                wr_seen++;
            end
            if (sram_oeb) oeb_seen++;
            if (out_valid && !seen_ov) begin
                seen_ov      = 1'b1;
                first_ov_cyc = cyc;
            end
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
            if (out_valid && out_ready) begin
                if (out_data !== gen(cur_seed, rx_cnt)) data_err++;
                if (out_last !== (rx_cnt == 207)) last_err++;
                if (out_last) last_hs_cyc = cyc;
                rx_cnt++;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   in_ready,   0);
        check({tag, "_out_valid"},  out_valid,  0);
        check({tag, "_out_last"},   out_last,   0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_wean"},       sram_wean,  1);
        check({tag, "_oeb"},        sram_oeb,   0);
        check({tag, "_sram_a"},     sram_a,     0);
        check({tag, "_sram_b"},     sram_b,     0);
        check({tag, "_sram_dia"},   sram_dia,   0);
    endtask

    task automatic run_frame(input string name, input logic [31:0] seed, input int vprob,
                             input int rprob, input bit hold, input int abort_at,
                             input bit mid_start);
        int wr_idx = 0;
        int budget = 0;
        int hold_cnt = 0;
        bit done = 1'b0;
        @(posedge CK); #1;
        cur_seed = seed; wr_seen = 0; oeb_seen = 0; rx_cnt = 0; data_err = 0;
        last_err = 0; addr_err = 0; wseq_err = 0; wdata_err = 0; stall_err = 0;
        fd_cnt = 0; fd_cyc = -1; last_hs_cyc = -1; first_ov_cyc = -1; first_acc_cyc = -1;
        seen_ov = 1'b0; seen_acc = 1'b0;
        while (!done && budget < 5000) begin
            if (budget > 0) begin
                @(posedge CK); #1;
            end
            start    = (budget == 0) || (mid_start && wr_idx == 50);
            in_valid = (wr_idx < 208) && ($urandom_range(99) < 32'(vprob));
            in_data  = gen(seed, wr_idx);
            if (hold && (wr_idx < 208 || hold_cnt < 5)) out_ready = 1'b0;
            else out_ready = ($urandom_range(99) < 32'(rprob));
            budget++;
            @(negedge CK);
            if (in_valid && in_ready) begin
                if (!seen_acc) begin
                    seen_acc      = 1'b1;
                    first_acc_cyc = cyc;
                end
                wr_idx++;
            end
            if (hold && wr_idx == 208 && hold_cnt < 5) begin
                hold_cnt++;
                if (hold_cnt == 5) begin
                    check({name, "_hold_writes"}, wr_seen, 208);
                    check({name, "_hold_reads"}, oeb_seen, 2);
                    check({name, "_hold_valid"}, out_valid, 1);
                    check({name, "_hold_in_ready"}, in_ready, 0);
                end
            end
            if (abort_at >= 0 && wr_idx == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_outputs({name, "_abort"});
                @(posedge CK); #1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                start     = 1'b0;
                check({name, "_abort_no_write"}, sram_wean, 1);
                @(posedge CK); #1;
                rst = 1'b0;
                return;
            end
            if (fd_cnt > 0) done = 1'b1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check({name, "_complete"}, done, 1);
        repeat (4) @(posedge CK);
        @(negedge CK);
        check({name, "_rx_count"},   rx_cnt,    208);
        check({name, "_data_order"}, data_err,  0);
        check({name, "_out_last"},   last_err,  0);
        check({name, "_writes"},     wr_seen,   208);
        check({name, "_wr_addr"},    wseq_err,  0);
        check({name, "_wr_data"},    wdata_err, 0);
        check({name, "_addr_sep"},   addr_err,  0);
        check({name, "_stall_hold"}, stall_err, 0);
        check({name, "_done_once"},  fd_cnt,    1);
        check({name, "_done_time"},  fd_cyc,    last_hs_cyc + 1);
        check({name, "_idle_busy"},  busy,      0);
    endtask

    initial begin
        @(negedge CK);
        check_reset_outputs("reset");
        check("reset_oea", sram_oea, 0);
        check("reset_webn", sram_webn, 1);
        check("reset_dib", sram_dib, 0);
        @(posedge CK); #1;
        rst = 1'b0;

        run_frame("full_rate", 32'd0, 100, 100, 1'b0, -1, 1'b0);
        check("full_rate_latency", first_ov_cyc - first_acc_cyc, 3);
        check("full_rate_throughput", last_hs_cyc - first_ov_cyc, 207);

        run_frame("random", 32'h1234_0001, 50, 30, 1'b0, -1, 1'b0);
        run_frame("held", 32'h1234_0002, 100, 100, 1'b1, -1, 1'b0);
        run_frame("aborted", 32'h1234_0003, 50, 100, 1'b0, 100, 1'b0);
        run_frame("after_reset", 32'h1234_0004, 100, 70, 1'b0, -1, 1'b0);
        run_frame("mid_start", 32'h1234_0005, 80, 60, 1'b0, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
